// File: rtl/dcache_stall_ctrl_pkg.sv
// Shared types for the D-cache stall controller: FSM state encoding and the
// bit positions of the packed stall/request vector used when observing outputs.
package dcache_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_REFILL    = 2'd3
  } state_t;

  localparam int STV_PC     = 0;
  localparam int STV_IFID   = 1;
  localparam int STV_IDEX   = 2;
  localparam int STV_FLUSH  = 3;
  localparam int STV_EXMEM  = 4;
  localparam int STV_BUBBLE = 5;
  localparam int STV_MEMEN  = 6;
  localparam int STV_MEMWR  = 7;
  localparam int STV_REFILL = 8;
  localparam int STV_W      = 9;

  typedef logic [STV_W-1:0] stall_vec_t;

endpackage

// File: rtl/dcache_stall_ctrl_if.sv
// Bundle between the MEM stage, hazard unit, off-chip memory port and the
// stall controller; master drives pipeline/memory status, slave returns controls.
interface dcache_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             mem_read_i;
  logic             mem_write_i;
  logic             cache_hit_i;
  logic             cache_dirty_i;
  logic             mem_ack_i;
  logic             load_use_i;
  logic             mem_enable_o;
  logic             mem_write_o;
  logic             refill_o;
  logic             pc_stall_o;
  logic             IF_ID_stall_o;
  logic             ID_EX_stall_o;
  logic             ID_EX_flush_o;
  logic             EX_MEM_stall_o;
  logic             MEM_WB_bubble_o;
  logic [CNT_W-1:0] miss_count_o;

  modport master (
    output mem_read_i, mem_write_i, cache_hit_i, cache_dirty_i, mem_ack_i, load_use_i,
    input  mem_enable_o, mem_write_o, refill_o, pc_stall_o, IF_ID_stall_o, ID_EX_stall_o,
    input  ID_EX_flush_o, EX_MEM_stall_o, MEM_WB_bubble_o, miss_count_o
  );

  modport slave (
    input  mem_read_i, mem_write_i, cache_hit_i, cache_dirty_i, mem_ack_i, load_use_i,
    output mem_enable_o, mem_write_o, refill_o, pc_stall_o, IF_ID_stall_o, ID_EX_stall_o,
    output ID_EX_flush_o, EX_MEM_stall_o, MEM_WB_bubble_o, miss_count_o
  );

endinterface

// File: rtl/dcache_stall_ctrl_sat_counter.sv
// Saturating up-counter with async active-low clear; value updates one cycle
// after inc is seen, holds at all-ones. No backpressure: inc is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dcache_stall_ctrl.sv
// D-cache miss stall controller: stalls are combinational (same cycle as miss),
// memory request/refill are registered from state; memory handshake is req/ack, no other backpressure.
module dcache_stall_ctrl
  import dcache_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_stall_ctrl_if.slave  bus
);

  state_t state;
  logic   access;
  logic   miss;
  logic   cache_stall;
  logic   mem_en_q;
  logic   mem_wr_q;
  logic   refill_q;
  logic   count_inc;

  assign access      = bus.mem_read_i | bus.mem_write_i;
  assign miss        = access & ~bus.cache_hit_i;
  assign cache_stall = (state != ST_IDLE) | miss;
  assign count_inc   = (state == ST_IDLE) & miss;

  // Request/refill flops are updated alongside the state so they always equal
  // a decode of the next state, keeping them glitch-free.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      refill_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss) begin
            mem_en_q <= 1'b1;
            if (bus.cache_dirty_i) begin
              state    <= ST_WRITEBACK;
              mem_wr_q <= 1'b1;
            end else begin
              state    <= ST_ALLOCATE;
              mem_wr_q <= 1'b0;
            end
          end
        end
        ST_WRITEBACK: begin
          if (bus.mem_ack_i) begin
            state    <= ST_ALLOCATE;
            mem_wr_q <= 1'b0;
          end
        end
        ST_ALLOCATE: begin
          if (bus.mem_ack_i) begin
            state    <= ST_REFILL;
            mem_en_q <= 1'b0;
            refill_q <= 1'b1;
          end
        end
        ST_REFILL: begin
          state    <= ST_IDLE;
          refill_q <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          refill_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_wr_q;
  assign bus.refill_o     = refill_q;

  // Cache stall wins over load-use; the held stages re-present the hazard later.
  assign bus.pc_stall_o      = cache_stall | bus.load_use_i;
  assign bus.IF_ID_stall_o   = cache_stall | bus.load_use_i;
  assign bus.ID_EX_stall_o   = cache_stall;
  assign bus.ID_EX_flush_o   = ~cache_stall & bus.load_use_i;
  assign bus.EX_MEM_stall_o  = cache_stall;
  assign bus.MEM_WB_bubble_o = cache_stall;

  sat_counter #(
    .W (CNT_W)
  ) u_miss_cnt (
    .clk   (clk_i),
    .clr_n (rst_i),
    .inc   (count_inc),
    .count (bus.miss_count_o)
  );

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Self-checking bench for dcache_stall_ctrl: a queue-of-pending-phases model
// predicts every output each cycle; a CNT_W=2 copy shares the stimulus for saturation.
module tb_dcache_stall_ctrl;
  import dcache_stall_ctrl_pkg::*;

  localparam int P_WB = 1;
  localparam int P_AL = 2;
  localparam int P_RF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_stall_ctrl_if #(.CNT_W(16)) bus ();
  dcache_stall_ctrl_if #(.CNT_W(2))  bus2 ();

  assign bus2.mem_read_i    = bus.mem_read_i;
  assign bus2.mem_write_i   = bus.mem_write_i;
  assign bus2.cache_hit_i   = bus.cache_hit_i;
  assign bus2.cache_dirty_i = bus.cache_dirty_i;
  assign bus2.mem_ack_i     = bus.mem_ack_i;
  assign bus2.load_use_i    = bus.load_use_i;

  dcache_stall_ctrl #(.CNT_W(16)) dut  (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  dcache_stall_ctrl #(.CNT_W(2))  dut2 (.clk_i(clk), .rst_i(rst_n), .bus(bus2));

  stall_vec_t dut_v;
  assign dut_v[STV_PC]     = bus.pc_stall_o;
  assign dut_v[STV_IFID]   = bus.IF_ID_stall_o;
  assign dut_v[STV_IDEX]   = bus.ID_EX_stall_o;
  assign dut_v[STV_FLUSH]  = bus.ID_EX_flush_o;
  assign dut_v[STV_EXMEM]  = bus.EX_MEM_stall_o;
  assign dut_v[STV_BUBBLE] = bus.MEM_WB_bubble_o;
  assign dut_v[STV_MEMEN]  = bus.mem_enable_o;
  assign dut_v[STV_MEMWR]  = bus.mem_write_o;
  assign dut_v[STV_REFILL] = bus.refill_o;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the list of memory phases still owed for the current miss.
  int ph[$];
  int age     = 0;
  int ack_dly = 1;
  int dly_cfg = 0;
  int misses  = 0;

  function automatic int front();
    if (ph.size() == 0) return 0;
    return ph[0];
  endfunction

  function automatic logic model_miss();
    return (bus.mem_read_i | bus.mem_write_i) & ~bus.cache_hit_i;
  endfunction

  function automatic stall_vec_t exp_vec();
    stall_vec_t v;
    logic busy, cs;
    v    = '0;
    busy = (ph.size() != 0);
    cs   = busy | model_miss();
    v[STV_PC]     = cs | bus.load_use_i;
    v[STV_IFID]   = cs | bus.load_use_i;
    v[STV_IDEX]   = cs;
    v[STV_FLUSH]  = ~cs & bus.load_use_i;
    v[STV_EXMEM]  = cs;
    v[STV_BUBBLE] = cs;
    v[STV_MEMEN]  = busy && (front() != P_RF);
    v[STV_MEMWR]  = (front() == P_WB);
    v[STV_REFILL] = (front() == P_RF);
    return v;
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (misses > 65535) ? 16'hffff : 16'(misses);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (misses > 3) ? 2'd3 : 2'(misses);
  endfunction

  function automatic logic ack_due();
    if (ph.size() == 0) return 1'b0;
    if (ph[0] == P_RF) return 1'b0;
    return (age >= ack_dly - 1);
  endfunction

  function automatic int pick_dly();
    return (dly_cfg != 0) ? dly_cfg : int'($urandom_range(1, 4));
  endfunction

  task automatic advance();
    @(posedge clk);
    if (ph.size() == 0) begin
      if (model_miss()) begin
        misses++;
        if (bus.cache_dirty_i) ph.push_back(P_WB);
        ph.push_back(P_AL);
        ph.push_back(P_RF);
        age     = 0;
        ack_dly = pick_dly();
      end
    end else if (ph[0] == P_RF) begin
      void'(ph.pop_front());
    end else if (bus.mem_ack_i) begin
      void'(ph.pop_front());
      age     = 0;
      ack_dly = pick_dly();
    end else begin
      age++;
    end
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic hit, input logic dirty, input logic lu);
    bus.mem_read_i    = rd;
    bus.mem_write_i   = wr;
    bus.cache_hit_i   = hit;
    bus.cache_dirty_i = dirty;
    bus.load_use_i    = lu;
  endtask

  task automatic test_reset();
    set_in(0, 0, 1, 0, 0);
    bus.mem_ack_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_v !== '0) begin
      n_err++; $display("FAIL reset_vec got=%b exp=%b", dut_v, stall_vec_t'(0));
    end
    n_checks++;
    if (bus.miss_count_o !== 16'd0 || bus2.miss_count_o !== 2'd0) begin
      n_err++; $display("FAIL reset_count got=%0d/%0d exp=0/0", bus.miss_count_o, bus2.miss_count_o);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_hits();
    for (int c = 0; c < 10; c++) begin
      set_in(1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
      bus.mem_ack_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec()) begin
        n_err++; $display("FAIL hits_vec c=%0d got=%b exp=%b", c, dut_v, exp_vec());
      end
      n_checks++;
      if (bus.miss_count_o !== 16'd0) begin
        n_err++; $display("FAIL hits_count got=%0d exp=0", bus.miss_count_o);
      end
      advance();
    end
  endtask

  task automatic test_clean_miss();
    int st = 0, rf = 0;
    logic seen = 1'b0, was_rf;
    dly_cfg = 3;
    for (int c = 0; c < 12; c++) begin
      set_in(1, 0, seen, 0, 0);
      bus.mem_ack_i = ack_due();
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec()) begin
        n_err++; $display("FAIL clean_vec c=%0d got=%b exp=%b", c, dut_v, exp_vec());
      end
      if (bus.EX_MEM_stall_o) st++;
      if (bus.refill_o) rf++;
      was_rf = (front() == P_RF);
      advance();
      if (was_rf) seen = 1'b1;
    end
    n_checks++;
    if (st != 5) begin
      n_err++; $display("FAIL clean_stall_cycles got=%0d exp=5", st);
    end
    n_checks++;
    if (rf != 1) begin
      n_err++; $display("FAIL clean_refill_cycles got=%0d exp=1", rf);
    end
    n_checks++;
    if (bus.miss_count_o !== 16'd1) begin
      n_err++; $display("FAIL clean_count got=%0d exp=1", bus.miss_count_o);
    end
  endtask

  task automatic test_dirty_miss();
    int phases = 0, wr_cyc = 0;
    logic seen = 1'b0, was_rf, prev_en = 1'b0, prev_wr = 1'b0;
    dly_cfg = 2;
    for (int c = 0; c < 12; c++) begin
      set_in(0, 1, seen, 1, 0);
      bus.mem_ack_i = ack_due();
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec()) begin
        n_err++; $display("FAIL dirty_vec c=%0d got=%b exp=%b", c, dut_v, exp_vec());
      end
      if (bus.mem_enable_o && (!prev_en || prev_wr != bus.mem_write_o)) phases++;
      if (bus.mem_enable_o && bus.mem_write_o) wr_cyc++;
      prev_en = bus.mem_enable_o;
      prev_wr = bus.mem_write_o;
      was_rf  = (front() == P_RF);
      advance();
      if (was_rf) seen = 1'b1;
    end
    n_checks++;
    if (phases != 2) begin
      n_err++; $display("FAIL dirty_phases got=%0d exp=2", phases);
    end
    n_checks++;
    if (wr_cyc != 2) begin
      n_err++; $display("FAIL dirty_writeback_cycles got=%0d exp=2", wr_cyc);
    end
    n_checks++;
    if (bus.miss_count_o !== 16'd2) begin
      n_err++; $display("FAIL dirty_count got=%0d exp=2", bus.miss_count_o);
    end
  endtask

  task automatic test_load_use();
    logic seen = 1'b0, was_rf, busy;
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 1);
      bus.mem_ack_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec()) begin
        n_err++; $display("FAIL lu_vec c=%0d got=%b exp=%b", c, dut_v, exp_vec());
      end
      n_checks++;
      if ({bus.pc_stall_o, bus.IF_ID_stall_o, bus.ID_EX_flush_o, bus.EX_MEM_stall_o} !== 4'b1110) begin
        n_err++; $display("FAIL lu_only got=%b exp=1110", {bus.pc_stall_o, bus.IF_ID_stall_o, bus.ID_EX_flush_o, bus.EX_MEM_stall_o});
      end
      advance();
    end
    dly_cfg = 2;
    for (int c = 0; c < 10; c++) begin
      set_in(1, 0, seen, 0, 1);
      bus.mem_ack_i = ack_due();
      busy = !seen;
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec()) begin
        n_err++; $display("FAIL lu_miss_vec c=%0d got=%b exp=%b", c, dut_v, exp_vec());
      end
      if (busy) begin
        n_checks++;
        if ({bus.ID_EX_flush_o, bus.pc_stall_o, bus.IF_ID_stall_o, bus.ID_EX_stall_o, bus.EX_MEM_stall_o} !== 5'b01111) begin
          n_err++; $display("FAIL lu_during_miss got=%b exp=01111", {bus.ID_EX_flush_o, bus.pc_stall_o, bus.IF_ID_stall_o, bus.ID_EX_stall_o, bus.EX_MEM_stall_o});
        end
      end
      was_rf = (front() == P_RF);
      advance();
      if (was_rf) seen = 1'b1;
    end
  endtask

  task automatic test_reset_mid_allocate();
    dly_cfg = 1000;
    set_in(1, 0, 0, 0, 0);
    bus.mem_ack_i = 1'b0;
    repeat (3) advance();
    #3 rst_n = 1'b0;
    #1;
    ph.delete();
    misses = 0;
    n_checks++;
    if (bus.mem_enable_o !== 1'b0 || bus.miss_count_o !== 16'd0) begin
      n_err++; $display("FAIL rst_mid_alloc en=%b cnt=%0d exp en=0 cnt=0", bus.mem_enable_o, bus.miss_count_o);
    end
    n_checks++;
    if (dut_v !== exp_vec()) begin
      n_err++; $display("FAIL rst_mid_vec got=%b exp=%b", dut_v, exp_vec());
    end
    set_in(0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      bus.mem_ack_i = (c == 0);
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec() || bus.miss_count_o !== 16'd0) begin
        n_err++; $display("FAIL late_ack c=%0d got=%b cnt=%0d exp=%b cnt=0", c, dut_v, bus.miss_count_o, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    logic [1:0] tbl [5];
    int k = 0;
    tbl[0] = 2'd1; tbl[1] = 2'd2; tbl[2] = 2'd3; tbl[3] = 2'd3; tbl[4] = 2'd3;
    dly_cfg = 1;
    for (int c = 0; c < 40 && k < 5; c++) begin
      set_in(1, 0, 0, 0, 0);
      bus.mem_ack_i = ack_due();
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec()) begin
        n_err++; $display("FAIL sat_vec c=%0d got=%b exp=%b", c, dut_v, exp_vec());
      end
      if (front() == P_RF) begin
        n_checks++;
        if (bus2.miss_count_o !== tbl[k]) begin
          n_err++; $display("FAIL sat_count2 miss=%0d got=%0d exp=%0d", k + 1, bus2.miss_count_o, tbl[k]);
        end
        k++;
      end
      advance();
    end
    n_checks++;
    if (k != 5) begin
      n_err++; $display("FAIL sat_timeout refills=%0d exp=5", k);
    end
    set_in(1, 0, 1, 0, 0);
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.miss_count_o !== 16'd5 || dut_v !== exp_vec()) begin
      n_err++; $display("FAIL sat_count16 got=%0d vec=%b exp=5 vec=%b", bus.miss_count_o, dut_v, exp_vec());
    end
    advance();
  endtask

  task automatic test_random();
    dly_cfg = 0;
    for (int c = 0; c < 600; c++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      bus.mem_ack_i = ack_due() | ($urandom_range(0, 15) == 0);
      @(negedge clk);
      n_checks++;
      if (dut_v !== exp_vec()) begin
        n_err++; $display("FAIL rand_vec c=%0d got=%b exp=%b", c, dut_v, exp_vec());
      end
      n_checks++;
      if (bus.miss_count_o !== exp_cnt16() || bus2.miss_count_o !== exp_cnt2()) begin
        n_err++; $display("FAIL rand_count c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.miss_count_o, bus2.miss_count_o, exp_cnt16(), exp_cnt2());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_clean_miss();
    test_dirty_miss();
    test_load_use();
    test_reset_mid_allocate();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_stall_ctrl.md
Name: dcache_stall_ctrl

Overview:
- Controls pipeline stalls on a data-cache miss in the 5-stage pipeline.
- Watches the MEM-stage access, which comes from the EX/MEM register outputs, together with the cache hit and dirty flags.
- Sequences a dirty-line write-back and a line allocate with off-chip data memory over a req/ack handshake.
- Drives the stall inputs of PC, IF/ID, ID/EX and EX/MEM, plus a bubble into MEM/WB. Also folds in the load-use stall from the hazard unit and keeps a miss counter.

Parameters:
- CNT_W, 16, width of the saturating miss counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- mem_read_i  in  1  MemRead at EX/MEM output
- mem_write_i  in  1  MemWrite at EX/MEM output
- cache_hit_i  in  1  tag match for the current MEM address
- cache_dirty_i  in  1  victim line dirty
- mem_ack_i  in  1  off-chip memory done, 1-cycle pulse
- load_use_i  in  1  load-use hazard from hazard unit
- mem_enable_o  out  1  off-chip request
- mem_write_o  out  1  1 = write-back, 0 = line read
- refill_o  out  1  cache writes the fetched line and clears dirty
- pc_stall_o  out  1  hold PC
- IF_ID_stall_o  out  1  hold IF/ID
- ID_EX_stall_o  out  1  hold ID/EX
- ID_EX_flush_o  out  1  insert bubble into ID/EX
- EX_MEM_stall_o  out  1  hold EX/MEM
- MEM_WB_bubble_o  out  1  MEM/WB captures RegWrite=0, MemtoReg=0
- miss_count_o  out  CNT_W  number of misses since reset

Behaviour:
- access = mem_read_i | mem_write_i; miss = access & ~cache_hit_i.
- States: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE:
  - miss & cache_dirty_i -> WRITEBACK.
  - miss & ~cache_dirty_i -> ALLOCATE.
  - Otherwise stay. mem_ack_i is ignored.
- WRITEBACK: mem_enable_o=1, mem_write_o=1. Hold until mem_ack_i, then -> ALLOCATE.
- ALLOCATE: mem_enable_o=1, mem_write_o=0. Hold until mem_ack_i, then -> REFILL.
- REFILL: refill_o=1 for exactly one cycle, then -> IDLE unconditionally.
  - The re-evaluated access hits next cycle, so stalls drop.
  - If it still misses, the cycle repeats. No special casing.
- An ack arriving the same cycle as entry into WRITEBACK/ALLOCATE cannot occur (mem_enable_o is not yet high). An ack outside WRITEBACK/ALLOCATE is ignored.
- cache_stall = miss in IDLE, or state != IDLE. It is combinational from state and inputs, so the stall is asserted in the same cycle the miss is seen.
- When cache_stall = 1:
  - pc_stall_o, IF_ID_stall_o, ID_EX_stall_o and EX_MEM_stall_o are all 1.
  - MEM_WB_bubble_o = 1.
  - ID_EX_flush_o = 0.
- When cache_stall = 0 and load_use_i = 1:
  - pc_stall_o = 1, IF_ID_stall_o = 1, ID_EX_flush_o = 1.
  - All others 0.
- Cache stall dominates load-use. On a simultaneous load-use, the load-use is resolved after the miss completes, because the stalled stages re-present it.
- mem_enable_o, mem_write_o and refill_o are decoded from the state register only. They are glitch-free and carry no input dependence.
- miss_count_o increments by 1 on each IDLE->WRITEBACK or IDLE->ALLOCATE transition. It saturates at all-ones and does not wrap.
- Total miss latency:
  - Clean miss: 1 (detect) + ack wait + 1 (REFILL).
  - Dirty miss: adds the write-back ack wait.
- Reset (rst_i=0, asynchronous, any state including mid-transaction):
  - State -> IDLE, miss_count_o -> 0.
  - mem_enable_o, mem_write_o and refill_o -> 0.
  - Stall, flush and bubble outputs are 0 unless the inputs alone demand them in IDLE.
  - An in-flight memory transaction is abandoned. The memory model must tolerate a dropped request.

Decomposition:
- Shared package holds:
  - State enum encoding (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2, REFILL=2'd3).
  - Stall-vector bit positions, used by the testbench checker.
- One natural sub-module: sat_counter (CNT_W-bit saturating increment with async active-low clear), used for miss_count_o.
- The FSM and stall decode stay in the top.

Test Plan:
- Hit traffic: mem_read_i=1, cache_hit_i=1 for 10 cycles -> all stalls 0, mem_enable_o=0, miss_count_o=0.
- Clean read miss, ack 3 cycles after request:
  - EX_MEM_stall_o high from the detect cycle through REFILL, total 5 cycles; refill_o high 1 cycle.
  - Stall drops the cycle hit returns; miss_count_o=1.
- Dirty write miss:
  - WRITEBACK with mem_write_o=1 until ack, then ALLOCATE with mem_write_o=0 until ack, then REFILL.
  - Exactly two mem_enable_o request phases; miss_count_o increments once.
- Load-use only: load_use_i=1, no access -> pc_stall_o=1, IF_ID_stall_o=1, ID_EX_flush_o=1, EX_MEM_stall_o=0. The same stimulus during a miss gives ID_EX_flush_o=0 and all stalls=1.
- rst_i pulsed low mid-ALLOCATE:
  - Immediately mem_enable_o=0 and miss_count_o=0.
  - A late mem_ack_i after release is ignored and the FSM stays in IDLE.
- Saturation: CNT_W=2 with 5 back-to-back clean misses -> miss_count_o reads 1, 2, 3, 3, 3.
